// File: rtl/gbx_pkg.sv
// Shared types and widths for the two-master GBX arbiter.
// Request and response bundles are grouped into structs so the arbiter can mux whole bundles.
package gbx_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 16;
    localparam int LEN_W  = 4;
    localparam int SIZE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WDATA = 2'd2,
        ST_RSP   = 2'd3
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
        logic              dvalid;
        logic [DATA_W-1:0] data;
        logic [SIZE_W-1:0] size;
        logic              dlast;
    } gbx_req_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              werr;
        logic              rerr;
        logic              last;
        logic [ID_W-1:0]   id;
    } gbx_rsp_t;

    // Beat counter increment that holds at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

endpackage

// File: rtl/gbx_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, on contention the master not granted last wins.
module gbx_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/gbx_arbiter2.sv
// Two-master to one-target GBX arbiter, one transaction outstanding at a time.
// Tracks write beat counts and aborts responses that never arrive.
module gbx_arbiter2
    import gbx_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 1024,
    parameter int          LEN_CHECK   = 1
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_greqvalid,
    input  logic              m0_greqwrite,
    input  logic [ADDR_W-1:0] m0_greqaddr,
    input  logic [LEN_W-1:0]  m0_greqlen,
    input  logic [ID_W-1:0]   m0_greqid,
    input  logic              m0_greqdvalid,
    input  logic [DATA_W-1:0] m0_greqdata,
    input  logic [SIZE_W-1:0] m0_greqsize,
    input  logic              m0_greqdlast,
    output logic              m0_greqready,
    output logic              m0_grspvalid,
    output logic [DATA_W-1:0] m0_grspdata,
    output logic              m0_grspwerr,
    output logic              m0_grsprerr,
    output logic              m0_grsplast,
    output logic [ID_W-1:0]   m0_grspid,
    input  logic              m0_grspready,

    input  logic              m1_greqvalid,
    input  logic              m1_greqwrite,
    input  logic [ADDR_W-1:0] m1_greqaddr,
    input  logic [LEN_W-1:0]  m1_greqlen,
    input  logic [ID_W-1:0]   m1_greqid,
    input  logic              m1_greqdvalid,
    input  logic [DATA_W-1:0] m1_greqdata,
    input  logic [SIZE_W-1:0] m1_greqsize,
    input  logic              m1_greqdlast,
    output logic              m1_greqready,
    output logic              m1_grspvalid,
    output logic [DATA_W-1:0] m1_grspdata,
    output logic              m1_grspwerr,
    output logic              m1_grsprerr,
    output logic              m1_grsplast,
    output logic [ID_W-1:0]   m1_grspid,
    input  logic              m1_grspready,

    output logic              s_greqvalid,
    output logic              s_greqwrite,
    output logic [ADDR_W-1:0] s_greqaddr,
    output logic [LEN_W-1:0]  s_greqlen,
    output logic [ID_W-1:0]   s_greqid,
    output logic              s_greqdvalid,
    output logic [DATA_W-1:0] s_greqdata,
    output logic [SIZE_W-1:0] s_greqsize,
    output logic              s_greqdlast,
    input  logic              s_greqready,
    input  logic              s_grspvalid,
    input  logic [DATA_W-1:0] s_grspdata,
    input  logic              s_grspwerr,
    input  logic              s_grsprerr,
    input  logic              s_grsplast,
    input  logic [ID_W-1:0]   s_grspid,
    output logic              s_grspready,

    output logic              grant,
    output logic              busy,
    output logic              err_len,
    output logic              err_tmo
);

    localparam logic [15:0] TMO_LAST = 16'(RSP_TIMEOUT - 1);

    gbx_req_t    m_req [2];
    gbx_req_t    sel_req;
    gbx_rsp_t    s_rsp;
    logic [1:0]  m_req_valid;
    logic [1:0]  m_rspready;
    logic        pick;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [15:0] tmo_q, tmo_d;
    logic        err_len_q, err_len_d;
    logic        err_tmo_q, err_tmo_d;
    logic        rsp_sink_q, rsp_sink_d;

    gbx_req_t    s_req_o;
    gbx_rsp_t    m_rsp_o [2];
    logic [1:0]  m_greqready_o;
    logic        s_grspready_o;
    logic        rsp_hs;

    assign m_req[0] = '{valid: m0_greqvalid, write: m0_greqwrite, addr: m0_greqaddr,
                        len: m0_greqlen, id: m0_greqid, dvalid: m0_greqdvalid,
                        data: m0_greqdata, size: m0_greqsize, dlast: m0_greqdlast};
    assign m_req[1] = '{valid: m1_greqvalid, write: m1_greqwrite, addr: m1_greqaddr,
                        len: m1_greqlen, id: m1_greqid, dvalid: m1_greqdvalid,
                        data: m1_greqdata, size: m1_greqsize, dlast: m1_greqdlast};
    assign s_rsp    = '{valid: s_grspvalid, data: s_grspdata, werr: s_grspwerr,
                        rerr: s_grsprerr, last: s_grsplast, id: s_grspid};

    assign m_req_valid = {m1_greqvalid, m0_greqvalid};
    assign m_rspready  = {m1_grspready, m0_grspready};
    assign sel_req     = m_req[grant_q];
    assign rsp_hs      = s_grspvalid & s_grspready_o;

    gbx_rr_pick2 u_pick (
        .req    (m_req_valid),
        .last   (last_q),
        .winner (pick)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        wr_d       = wr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        tmo_d      = tmo_q;
        err_len_d  = err_len_q;
        err_tmo_d  = err_tmo_q;
        rsp_sink_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (|m_req_valid) begin
                    grant_d = pick;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (sel_req.valid && s_greqready) begin
                    wr_d    = sel_req.write;
                    len_d   = sel_req.len;
                    beat_d  = '0;
                    tmo_d   = '0;
                    state_d = sel_req.write ? ST_WDATA : ST_RSP;
                end
            end
            ST_WDATA: begin
                if (sel_req.dvalid && s_greqready) begin
                    beat_d = sat_inc(beat_q);
                    if (sel_req.dlast) begin
                        // count+1 != len+1 reduces to comparing the pre-increment count with len
                        if ((LEN_CHECK != 0) && wr_q && (beat_q != len_q)) begin
                            err_len_d = 1'b1;
                        end
                        tmo_d   = '0;
                        state_d = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_hs) begin
                    tmo_d = '0;
                    if (s_grsplast) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    last_d    = grant_q;
                    tmo_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Forwarding muxes depend only on state and the selected master, never on s_grsp* for m*_greq*.
    always_comb begin
        s_req_o       = '0;
        m_rsp_o[0]    = '0;
        m_rsp_o[1]    = '0;
        m_greqready_o = 2'b00;
        s_grspready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s_grspready_o = rsp_sink_q;
            end
            ST_ADDR: begin
                s_req_o = sel_req;
                if (grant_q) m_greqready_o[1] = s_greqready;
                else         m_greqready_o[0] = s_greqready;
            end
            ST_WDATA: begin
                s_req_o.dvalid = sel_req.dvalid;
                s_req_o.data   = sel_req.data;
                s_req_o.dlast  = sel_req.dlast;
                if (grant_q) m_greqready_o[1] = s_greqready;
                else         m_greqready_o[0] = s_greqready;
            end
            ST_RSP: begin
                if (grant_q) m_rsp_o[1] = s_rsp;
                else         m_rsp_o[0] = s_rsp;
                s_grspready_o = m_rspready[grant_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            wr_q       <= 1'b0;
            len_q      <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            // Keeps s_grspready low while reset is held even though IDLE normally sinks responses.
            rsp_sink_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            err_len_q  <= err_len_d;
            err_tmo_q  <= err_tmo_d;
            rsp_sink_q <= rsp_sink_d;
        end
    end

    assign s_greqvalid  = s_req_o.valid;
    assign s_greqwrite  = s_req_o.write;
    assign s_greqaddr   = s_req_o.addr;
    assign s_greqlen    = s_req_o.len;
    assign s_greqid     = s_req_o.id;
    assign s_greqdvalid = s_req_o.dvalid;
    assign s_greqdata   = s_req_o.data;
    assign s_greqsize   = s_req_o.size;
    assign s_greqdlast  = s_req_o.dlast;
    assign s_grspready  = s_grspready_o;

    assign m0_greqready = m_greqready_o[0];
    assign m0_grspvalid = m_rsp_o[0].valid;
    assign m0_grspdata  = m_rsp_o[0].data;
    assign m0_grspwerr  = m_rsp_o[0].werr;
    assign m0_grsprerr  = m_rsp_o[0].rerr;
    assign m0_grsplast  = m_rsp_o[0].last;
    assign m0_grspid    = m_rsp_o[0].id;

    assign m1_greqready = m_greqready_o[1];
    assign m1_grspvalid = m_rsp_o[1].valid;
    assign m1_grspdata  = m_rsp_o[1].data;
    assign m1_grspwerr  = m_rsp_o[1].werr;
    assign m1_grsprerr  = m_rsp_o[1].rerr;
    assign m1_grsplast  = m_rsp_o[1].last;
    assign m1_grspid    = m_rsp_o[1].id;

    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign err_len = err_len_q;
    assign err_tmo = err_tmo_q;

endmodule

// File: tb/tb_gbx_arbiter2.sv
// Directed bench for gbx_arbiter2: reads, contention order, burst writes, length error,
// response timeout and mid-transaction reset, with hand-computed expectations.
module tb_gbx_arbiter2;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        m0_greqvalid, m0_greqwrite, m0_greqdvalid, m0_greqdlast, m0_grspready;
    logic [31:0] m0_greqaddr, m0_greqdata;
    logic [3:0]  m0_greqlen;
    logic [15:0] m0_greqid;
    logic [1:0]  m0_greqsize;
    logic        m0_greqready, m0_grspvalid, m0_grspwerr, m0_grsprerr, m0_grsplast;
    logic [31:0] m0_grspdata;
    logic [15:0] m0_grspid;

    logic        m1_greqvalid, m1_greqwrite, m1_greqdvalid, m1_greqdlast, m1_grspready;
    logic [31:0] m1_greqaddr, m1_greqdata;
    logic [3:0]  m1_greqlen;
    logic [15:0] m1_greqid;
    logic [1:0]  m1_greqsize;
    logic        m1_greqready, m1_grspvalid, m1_grspwerr, m1_grsprerr, m1_grsplast;
    logic [31:0] m1_grspdata;
    logic [15:0] m1_grspid;

    logic        s_greqvalid, s_greqwrite, s_greqdvalid, s_greqdlast, s_greqready;
    logic [31:0] s_greqaddr, s_greqdata;
    logic [3:0]  s_greqlen;
    logic [15:0] s_greqid;
    logic [1:0]  s_greqsize;
    logic        s_grspvalid, s_grspwerr, s_grsprerr, s_grsplast, s_grspready;
    logic [31:0] s_grspdata;
    logic [15:0] s_grspid;

    logic        grant, busy, err_len, err_tmo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gbx_arbiter2 #(.RSP_TIMEOUT(8), .LEN_CHECK(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_greqvalid(m0_greqvalid), .m0_greqwrite(m0_greqwrite), .m0_greqaddr(m0_greqaddr),
        .m0_greqlen(m0_greqlen), .m0_greqid(m0_greqid), .m0_greqdvalid(m0_greqdvalid),
        .m0_greqdata(m0_greqdata), .m0_greqsize(m0_greqsize), .m0_greqdlast(m0_greqdlast),
        .m0_greqready(m0_greqready), .m0_grspvalid(m0_grspvalid), .m0_grspdata(m0_grspdata),
        .m0_grspwerr(m0_grspwerr), .m0_grsprerr(m0_grsprerr), .m0_grsplast(m0_grsplast),
        .m0_grspid(m0_grspid), .m0_grspready(m0_grspready),
        .m1_greqvalid(m1_greqvalid), .m1_greqwrite(m1_greqwrite), .m1_greqaddr(m1_greqaddr),
        .m1_greqlen(m1_greqlen), .m1_greqid(m1_greqid), .m1_greqdvalid(m1_greqdvalid),
        .m1_greqdata(m1_greqdata), .m1_greqsize(m1_greqsize), .m1_greqdlast(m1_greqdlast),
        .m1_greqready(m1_greqready), .m1_grspvalid(m1_grspvalid), .m1_grspdata(m1_grspdata),
        .m1_grspwerr(m1_grspwerr), .m1_grsprerr(m1_grsprerr), .m1_grsplast(m1_grsplast),
        .m1_grspid(m1_grspid), .m1_grspready(m1_grspready),
        .s_greqvalid(s_greqvalid), .s_greqwrite(s_greqwrite), .s_greqaddr(s_greqaddr),
        .s_greqlen(s_greqlen), .s_greqid(s_greqid), .s_greqdvalid(s_greqdvalid),
        .s_greqdata(s_greqdata), .s_greqsize(s_greqsize), .s_greqdlast(s_greqdlast),
        .s_greqready(s_greqready), .s_grspvalid(s_grspvalid), .s_grspdata(s_grspdata),
        .s_grspwerr(s_grspwerr), .s_grsprerr(s_grsprerr), .s_grsplast(s_grsplast),
        .s_grspid(s_grspid), .s_grspready(s_grspready),
        .grant(grant), .busy(busy), .err_len(err_len), .err_tmo(err_tmo)
    );

    task automatic clear_inputs();
        m0_greqvalid = 0; m0_greqwrite = 0; m0_greqaddr = 0; m0_greqlen = 0; m0_greqid = 0;
        m0_greqdvalid = 0; m0_greqdata = 0; m0_greqsize = 0; m0_greqdlast = 0; m0_grspready = 1;
        m1_greqvalid = 0; m1_greqwrite = 0; m1_greqaddr = 0; m1_greqlen = 0; m1_greqid = 0;
        m1_greqdvalid = 0; m1_greqdata = 0; m1_greqsize = 0; m1_greqdlast = 0; m1_grspready = 1;
        s_greqready = 1; s_grspvalid = 0; s_grspdata = 0; s_grspwerr = 0; s_grsprerr = 0;
        s_grsplast = 0; s_grspid = 0;
    endtask

    // Serves one pending len-0 read from master g; the DUT must reach ADDR at the next negedge.
    task automatic serve_read(input logic g, input logic [31:0] addr, input logic [31:0] rdata,
                              input logic [15:0] id);
        @(negedge clk); s_grspvalid = 0; #1;
        n_tests++; if (busy !== 1'b1 || grant !== g) begin n_fail++;
            $display("FAIL rd_grant: busy=%b grant=%b expected busy=1 grant=%b", busy, grant, g); end
        n_tests++; if (s_greqvalid !== 1'b1 || s_greqaddr !== addr || s_greqwrite !== 1'b0) begin n_fail++;
            $display("FAIL rd_addr_fwd: valid=%b addr=%h wr=%b expected 1 %h 0", s_greqvalid, s_greqaddr, s_greqwrite, addr); end
        n_tests++; if ((g ? m1_greqready : m0_greqready) !== 1'b1 || (g ? m0_greqready : m1_greqready) !== 1'b0) begin n_fail++;
            $display("FAIL rd_ready: m0=%b m1=%b expected owner only for m%0d", m0_greqready, m1_greqready, g); end
        @(negedge clk);
        if (g) m1_greqvalid = 0; else m0_greqvalid = 0;
        s_grspvalid = 1; s_grspdata = rdata; s_grsplast = 1; s_grspid = id; #1;
        n_tests++; if ((g ? m1_grspvalid : m0_grspvalid) !== 1'b1 || (g ? m1_grspdata : m0_grspdata) !== rdata
                       || (g ? m1_grsplast : m0_grsplast) !== 1'b1 || (g ? m1_grspid : m0_grspid) !== id) begin n_fail++;
            $display("FAIL rd_rsp: owner rsp data=%h expected %h id %h", g ? m1_grspdata : m0_grspdata, rdata, id); end
        n_tests++; if ((g ? m0_grspvalid : m1_grspvalid) !== 1'b0 || s_greqvalid !== 1'b0 || s_grspready !== 1'b1) begin n_fail++;
            $display("FAIL rd_rsp_iso: other_valid=%b s_greqvalid=%b s_grspready=%b expected 0 0 1",
                     g ? m0_grspvalid : m1_grspvalid, s_greqvalid, s_grspready); end
        @(negedge clk); s_grspvalid = 0; s_grsplast = 0; s_grspdata = 0; #1;
        n_tests++; if (busy !== 1'b0 || m0_grspvalid !== 1'b0 || m1_grspvalid !== 1'b0) begin n_fail++;
            $display("FAIL rd_done: busy=%b expected 0 after last beat", busy); end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        m0_greqvalid = 1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (busy !== 1'b0 || grant !== 1'b0 || err_len !== 1'b0 || err_tmo !== 1'b0) begin n_fail++;
            $display("FAIL rst_status: busy=%b grant=%b err_len=%b err_tmo=%b expected all 0", busy, grant, err_len, err_tmo); end
        n_tests++; if (m0_greqready !== 1'b0 || s_greqvalid !== 1'b0 || s_grspready !== 1'b0 || s_greqaddr !== 32'h0) begin n_fail++;
            $display("FAIL rst_outputs: m0_greqready=%b s_greqvalid=%b s_grspready=%b expected 0", m0_greqready, s_greqvalid, s_grspready); end
        m0_greqvalid = 0;
        reset_n = 1;
        @(negedge clk); #1;
        n_tests++; if (busy !== 1'b0 || s_grspready !== 1'b1) begin n_fail++;
            $display("FAIL idle_sink: busy=%b s_grspready=%b expected 0 1", busy, s_grspready); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m0_greqvalid = 1; m0_greqwrite = 0; m0_greqaddr = 32'h100; m0_greqlen = 0; m0_greqid = 16'h11;
        serve_read(1'b0, 32'h100, 32'hDEADBEEF, 16'h11);
    endtask

    task automatic test_contention(input logic first);
        @(negedge clk);
        m0_greqvalid = 1; m0_greqwrite = 0; m0_greqaddr = 32'h200; m0_greqlen = 0; m0_greqid = 16'h20;
        m1_greqvalid = 1; m1_greqwrite = 0; m1_greqaddr = 32'h300; m1_greqlen = 0; m1_greqid = 16'h30;
        serve_read(first, first ? 32'h300 : 32'h200, 32'hA000_0001, first ? 16'h30 : 16'h20);
        serve_read(~first, first ? 32'h200 : 32'h300, 32'hA000_0002, first ? 16'h20 : 16'h30);
    endtask

    task automatic test_burst_write();
        int beats_seen;
        beats_seen = 0;
        @(negedge clk);
        m1_greqvalid = 1; m1_greqwrite = 1; m1_greqaddr = 32'h400; m1_greqlen = 4'd3; m1_greqid = 16'h41; m1_greqsize = 2'd2;
        @(negedge clk); #1;
        n_tests++; if (grant !== 1'b1 || s_greqwrite !== 1'b1 || s_greqlen !== 4'd3 || s_greqsize !== 2'd2) begin n_fail++;
            $display("FAIL wr_addr: grant=%b write=%b len=%0d size=%0d expected 1 1 3 2", grant, s_greqwrite, s_greqlen, s_greqsize); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            m1_greqvalid = 0; m1_greqdvalid = 1; m1_greqdata = i; m1_greqdlast = (i == 4); #1;
            if (s_greqdvalid && s_greqready && m1_greqready && !s_greqvalid && s_greqdata == 32'(i)
                && s_greqdlast == (i == 4)) beats_seen++;
        end
        @(negedge clk);
        m1_greqdvalid = 0; m1_greqdlast = 0;
        s_grspvalid = 1; s_grsplast = 1; s_grspwerr = 0; s_grspid = 16'h41; #1;
        n_tests++; if (beats_seen !== 4) begin n_fail++;
            $display("FAIL wr_beats: forwarded %0d beats expected 4", beats_seen); end
        n_tests++; if (m1_grspvalid !== 1'b1 || m1_grspwerr !== 1'b0 || m0_grspvalid !== 1'b0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL wr_rsp: m1_grspvalid=%b m0_grspvalid=%b busy=%b expected 1 0 1", m1_grspvalid, m0_grspvalid, busy); end
        @(negedge clk); s_grspvalid = 0; s_grsplast = 0; #1;
        n_tests++; if (busy !== 1'b0 || err_len !== 1'b0) begin n_fail++;
            $display("FAIL wr_done: busy=%b err_len=%b expected 0 0", busy, err_len); end
    endtask

    task automatic test_len_error();
        @(negedge clk);
        m0_greqvalid = 1; m0_greqwrite = 1; m0_greqaddr = 32'h480; m0_greqlen = 4'd1; m0_greqid = 16'h51;
        @(negedge clk); #1;
        n_tests++; if (grant !== 1'b0 || s_greqvalid !== 1'b1) begin n_fail++;
            $display("FAIL len_grant: grant=%b s_greqvalid=%b expected 0 1", grant, s_greqvalid); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            m0_greqvalid = 0; m0_greqdvalid = 1; m0_greqdata = 32'h50 + i; m0_greqdlast = (i == 3); #1;
            if (i == 3) begin
                n_tests++; if (err_len !== 1'b0 || s_greqdlast !== 1'b1) begin n_fail++;
                    $display("FAIL len_pre: err_len=%b dlast=%b expected 0 1", err_len, s_greqdlast); end
            end
        end
        @(negedge clk);
        m0_greqdvalid = 0; m0_greqdlast = 0;
        s_grspvalid = 1; s_grsplast = 1; #1;
        n_tests++; if (err_len !== 1'b1 || busy !== 1'b1 || m0_grspvalid !== 1'b1) begin n_fail++;
            $display("FAIL len_set: err_len=%b busy=%b m0_grspvalid=%b expected 1 1 1", err_len, busy, m0_grspvalid); end
        @(negedge clk); s_grspvalid = 0; s_grsplast = 0; #1;
        n_tests++; if (err_len !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL len_sticky: err_len=%b busy=%b expected 1 0", err_len, busy); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        m0_greqvalid = 1; m0_greqwrite = 0; m0_greqaddr = 32'h500; m0_greqlen = 0; m0_greqid = 16'h61;
        @(negedge clk); #1;
        n_tests++; if (grant !== 1'b0 || s_greqaddr !== 32'h500) begin n_fail++;
            $display("FAIL tmo_grant: grant=%b addr=%h expected 0 500", grant, s_greqaddr); end
        @(negedge clk); m0_greqvalid = 0;
        repeat (7) @(negedge clk);
        #1;
        n_tests++; if (err_tmo !== 1'b0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL tmo_early: after 7 RSP cycles err_tmo=%b busy=%b expected 0 1", err_tmo, busy); end
        @(negedge clk);
        s_grspvalid = 1; s_grsplast = 1; s_grspdata = 32'hBAD0_BAD0;
        m0_greqvalid = 1; m0_greqaddr = 32'h600; m0_greqid = 16'h62;
        m1_greqvalid = 1; m1_greqwrite = 0; m1_greqaddr = 32'h700; m1_greqlen = 0; m1_greqid = 16'h72; #1;
        n_tests++; if (err_tmo !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL tmo_fire: after 8 RSP cycles err_tmo=%b busy=%b expected 1 0", err_tmo, busy); end
        n_tests++; if (s_grspready !== 1'b1 || m0_grspvalid !== 1'b0 || m1_grspvalid !== 1'b0) begin n_fail++;
            $display("FAIL tmo_late_drop: s_grspready=%b m0_grspvalid=%b expected 1 0", s_grspready, m0_grspvalid); end
        serve_read(1'b1, 32'h700, 32'hC0DE_0001, 16'h72);
        serve_read(1'b0, 32'h600, 32'hC0DE_0002, 16'h62);
        n_tests++; if (err_tmo !== 1'b1 || err_len !== 1'b1) begin n_fail++;
            $display("FAIL err_sticky: err_tmo=%b err_len=%b expected 1 1", err_tmo, err_len); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m1_greqvalid = 1; m1_greqwrite = 1; m1_greqaddr = 32'h900; m1_greqlen = 4'd1; m1_greqid = 16'h91;
        @(negedge clk);
        @(negedge clk);
        m1_greqvalid = 0; m1_greqdvalid = 1; m1_greqdata = 32'hAA; #1;
        n_tests++; if (s_greqdvalid !== 1'b1 || s_greqdata !== 32'hAA) begin n_fail++;
            $display("FAIL mid_wdata: dvalid=%b data=%h expected 1 aa", s_greqdvalid, s_greqdata); end
        #1 reset_n = 0;
        #1;
        n_tests++; if (busy !== 1'b0 || grant !== 1'b0 || err_len !== 1'b0 || err_tmo !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_status: busy=%b grant=%b err_len=%b err_tmo=%b expected 0", busy, grant, err_len, err_tmo); end
        n_tests++; if (s_greqdvalid !== 1'b0 || s_greqdata !== 32'h0 || m1_greqready !== 1'b0 || s_grspready !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_outputs: dvalid=%b data=%h m1_greqready=%b s_grspready=%b expected 0", s_greqdvalid, s_greqdata, m1_greqready, s_grspready); end
        clear_inputs();
        @(negedge clk); reset_n = 1;
        @(negedge clk);
        m0_greqvalid = 1; m0_greqwrite = 0; m0_greqaddr = 32'h800; m0_greqlen = 0; m0_greqid = 16'h81;
        serve_read(1'b0, 32'h800, 32'h1234_5678, 16'h81);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention(1'b0);
        test_single_read();
        test_contention(1'b1);
        test_burst_write();
        test_len_error();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
